mccoy_host: RTL
===============

# mccoy_host

Host-side driver for the McCoy 6-bit core: it drives the core's 8-bit input bus and reads the core's 8-bit output bus. It holds a 64-entry program memory and generates the core clock and core reset. It answers each PC the core presents with the instruction at that address, and captures the x8 value the core presents on the opposite clock phase. It sits on the test/FPGA side of the chip pins, so a program can run on the core with no external instruction source.

## Interface
- `DIV`, default 2: system clocks per core-clock half-period; legal values are 2 and up.
- `clk` in 1: system clock, the only clock.
- `reset` in 1: synchronous, active-low.
- `wr_en` in 1: program write strobe; accepted only in IDLE.
- `wr_addr` in 6: program write address.
- `wr_data` in 6: instruction word; bits [2:0] are the opcode, bits [5:3] are the reg/imm field.
- `start` in 1: single-cycle pulse that begins a run; accepted only in IDLE.
- `stop` in 1: pulse that ends a run early; accepted only in RUN.
- `max_steps` in 8: number of core cycles to run; 0 means run until `stop`.
- `core_out` in 8: the core's output bus. It shows the PC while the core clock is high and x8 while it is low.
- `core_in` out 8: the core's input bus. Bit [0] is the core clock, bit [1] is the core reset (active-high), bits [7:2] are the instruction.
- `pc_val` out 6: last PC captured from the core.
- `x8_val` out 6: last x8 captured from the core.
- `x8_valid` out 1: one-cycle pulse when `x8_val` updates.
- `step_cnt` out 8: number of completed core cycles in the current run.
- `running` out 1: high in RST_CORE and RUN.
- `done` out 1: one-cycle pulse when a run ends.

## Operation
- FSM states: IDLE, RST_CORE, RUN, DONE.
- **Phase generator:**
  - `ph_cnt` counts 0..DIV-1 in RST_CORE and RUN.
  - On the cycle where `ph_cnt==DIV-1`, the core clock `cclk` (`core_in[0]`) toggles and `ph_cnt` returns to 0.
  - In IDLE and DONE, `cclk=0` and `ph_cnt=0`.
- **IDLE:**
  - `wr_en` writes `mem[wr_addr] <= wr_data`.
  - `start` moves to RST_CORE and clears `step_cnt`, `pc_val` and `x8_val`.
  - `core_in = {6'b0, 1'b1, 1'b0}`: core held in reset, instruction 0.
- **RST_CORE:**
  - `core_in[1]=1`, instruction 0.
  - Lasts 2 full core-clock periods (4·DIV system cycles, i.e. 2 rising edges with reset asserted).
  - Then moves to RUN with `core_in[1]=0` and the instruction bits set to `mem[0]`.
- **RUN**, acting on the last cycle of each phase (`ph_cnt==DIV-1`):
  - If `cclk==1` (end of high phase):
    - `pc_val <= core_out[5:0]`.
    - Instruction register `<= mem[core_out[5:0]]`; it stays stable until the next such sample, so it is stable across the next rising edge.
  - If `cclk==0` (end of low phase) and at least one rising edge has occurred in RUN:
    - `x8_val <= core_out[5:0]`, `x8_valid=1`, `step_cnt <= step_cnt+1`.
    - If `max_steps!=0` and `step_cnt+1==max_steps`, or a stop is pending, move to DONE and suppress the toggle, so `cclk` stays 0.
- **`stop`:** the pulse sets a pending flag. The run ends at the next x8 sample, so the current core cycle always completes.
- **`step_cnt`:** wraps from 255 to 0 when `max_steps==0`.
- **DONE:** `done=1` for one cycle, then IDLE.
- **Ignored inputs:** `start` outside IDLE, `wr_en` outside IDLE, and `stop` outside RUN are all ignored. `start` and `wr_en` in the same IDLE cycle: the write happens and the start is taken.
- **Reset values:**
  - `core_in=8'h02`; `pc_val`, `x8_val` and `step_cnt` are 0; `x8_valid`, `running` and `done` are 0; state IDLE.
  - `mem` is not reset.
- **Reset mid-run:** on the next edge everything returns to the reset values. `cclk` drops to 0 and the core is held in reset.

## Timing
- One core-clock period is 2·DIV system clocks.
- Start to first core rising edge out of reset: 1 cycle (IDLE→RST_CORE) + 4·DIV + DIV.
- `core_out` is sampled DIV-1 cycles after each `cclk` toggle, which gives the core a settle margin.
- The instruction for address p is driven at least 1 system cycle before the rising edge that consumes it. The latency from PC sample to instruction is 1 cycle, from a combinational memory read.
- `x8_valid` and the `step_cnt` increment occur in the same cycle. `done` follows 1 cycle after the final `x8_valid`.
- `running` rises the cycle after `start` and falls when DONE is entered.

## Test plan
All scenarios use DIV=2 and a behavioural McCoy model on `core_in`/`core_out`.
- **Program load:** write `mem[0..3]` = 6'h01, 6'h0A, 6'h13, 6'h05, then start with `max_steps=4` -> the core sees those 4 instructions in order; `x8_valid` pulses exactly 4 times; `done` pulses 1 cycle after the 4th pulse; `cclk` ends at 0.
- **Clock/reset shape:** start -> `core_in[1]=1` for exactly 8 cycles; `cclk` period is 4 cycles; `running` is high from cycle 1 until DONE.
- **Branch:** program with a jump to address 0x20 -> `pc_val` reads 0x20 and the instruction bits equal `mem[0x20]` before the next rising edge.
- **Stop:** `max_steps=0`, `stop` pulsed mid high-phase of step 5 -> step 5's `x8_valid` still fires; `step_cnt=5`; then `done`.
- **Reset mid-run:** assert `reset=0` during RUN -> next cycle `core_in=8'h02`, `step_cnt=0`, state IDLE; `mem` contents are preserved, so a re-run gives identical x8 values.
- **Illegal requests:** `wr_en` and `start` during RUN are ignored -> memory is unchanged and the run is not restarted.

Source files
------------

// File: rtl/mccoy_host.sv
// Host driver for the McCoy 6-bit core: program memory, core clock/reset generation, PC/x8 capture.
// Instruction follows a PC sample by 1 cycle; no backpressure, the core clock runs freely at 2*DIV cycles per period.
module mccoy_host #(
  parameter int DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [5:0] wr_data,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] max_steps,
  input  logic [7:0] core_out,
  output logic [7:0] core_in,
  output logic [5:0] pc_val,
  output logic [5:0] x8_val,
  output logic       x8_valid,
  output logic [7:0] step_cnt,
  output logic       running,
  output logic       done
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, RST_CORE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [5:0]     mem [0:63];
  logic [PW-1:0]  ph_cnt;
  logic           cclk;
  logic [1:0]     rst_tog;
  logic [5:0]     instr;
  logic           seen_rise;
  logic           stop_pend;
  logic           ph_last;
  logic           hi_sample;
  logic           lo_sample;
  logic           run_end;
  logic           rst_end;
  logic [7:0]     step_nxt;
  logic           core_out_unused;

  assign core_out_unused = ^core_out[7:6];

  assign ph_last   = (ph_cnt == PW'(DIV - 1));
  assign step_nxt  = step_cnt + 8'd1;
  assign hi_sample = (state == RUN) && ph_last && cclk;
  assign lo_sample = (state == RUN) && ph_last && !cclk && seen_rise;
  // A stop arriving on the sample cycle itself also ends the run there.
  assign run_end   = lo_sample &&
                     (((max_steps != 8'd0) && (step_nxt == max_steps)) || stop_pend || stop);
  assign rst_end   = (state == RST_CORE) && ph_last && (rst_tog == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start)   state_nxt = RST_CORE;
      RST_CORE: if (rst_end) state_nxt = RUN;
      RUN:      if (run_end) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ph_cnt    <= '0;
      cclk      <= 1'b0;
      rst_tog   <= 2'd0;
      instr     <= 6'd0;
      seen_rise <= 1'b0;
      stop_pend <= 1'b0;
      pc_val    <= 6'd0;
      x8_val    <= 6'd0;
      x8_valid  <= 1'b0;
      step_cnt  <= 8'd0;
      done      <= 1'b0;
    end else begin
      x8_valid <= 1'b0;
      done     <= (state == DONE);
      case (state)
        IDLE: begin
          ph_cnt <= '0;
          cclk   <= 1'b0;
          if (start) begin
            step_cnt  <= 8'd0;
            pc_val    <= 6'd0;
            x8_val    <= 6'd0;
            stop_pend <= 1'b0;
            seen_rise <= 1'b0;
            rst_tog   <= 2'd0;
          end
        end
        RST_CORE: begin
          ph_cnt <= ph_last ? '0 : ph_cnt + PW'(1);
          if (ph_last) begin
            cclk    <= ~cclk;
            rst_tog <= rst_tog + 2'd1;
          end
          if (rst_end) instr <= mem[0];
        end
        RUN: begin
          ph_cnt <= ph_last ? '0 : ph_cnt + PW'(1);
          if (stop) stop_pend <= 1'b1;
          if (ph_last && !run_end) cclk <= ~cclk;
          // End of high phase: PC is on the bus; fetch so the instruction is stable before the next rise.
          if (hi_sample) begin
            pc_val    <= core_out[5:0];
            instr     <= mem[core_out[5:0]];
            seen_rise <= 1'b1;
          end
          if (lo_sample) begin
            x8_val   <= core_out[5:0];
            x8_valid <= 1'b1;
            step_cnt <= step_nxt;
          end
        end
        DONE: begin
          ph_cnt <= '0;
          cclk   <= 1'b0;
        end
        default: begin
          ph_cnt <= '0;
          cclk   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    core_in = {6'd0, 1'b1, 1'b0};
    case (state)
      RST_CORE: core_in = {6'd0, 1'b1, cclk};
      RUN:      core_in = {instr, 1'b0, cclk};
      default:  core_in = {6'd0, 1'b1, 1'b0};
    endcase
  end

  assign running = (state == RST_CORE) || (state == RUN);

endmodule
